mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-access (MEM) stage load/store unit of the MIPS32 pipeline; the producing end of the MEM/WB interface.
- Takes EX/MEM control and data, runs a req/ack transaction to data memory, and aligns and extends load data.
- Drives RegWrite_MEM, MemtoReg_MEM, Read_Data_MEM, ALU_Result_MEM and Write_Register_MEM into the MEM/WB register.
- Asserts Stall_MEM to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data width; fixed at 32, lane logic assumes 4 bytes

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- MemRead_in  in  1  load in MEM stage
- MemWrite_in  in  1  store in MEM stage
- MemSize_in  in  2  00 byte, 01 half, 10 word; 11 treated as word
- MemSigned_in  in  1  1 = sign-extend loads (LB/LH), 0 = zero-extend (LBU/LHU)
- RegWrite_in  in  1  from EX/MEM
- MemtoReg_in  in  1  from EX/MEM
- ALU_Result_in  in  32  effective address, or ALU result
- Write_Data_in  in  32  store data (rt)
- Write_Register_in  in  5  destination register
- RegWrite_MEM  out  1  to MEM/WB
- MemtoReg_MEM  out  1  to MEM/WB
- Read_Data_MEM  out  32  aligned and extended load data
- ALU_Result_MEM  out  32  pass-through
- Write_Register_MEM  out  5  pass-through
- Stall_MEM  out  1  pipeline freeze
- Addr_Exception  out  1  misaligned access flag; tied 0 unless MISALIGN_TRAP_EN
- Mem_Req  out  1  bus request, registered
- Mem_We  out  1  1 = write
- Mem_Addr  out  32  word address; bits [1:0] always 00
- Mem_Byte_En  out  4  byte lane enables
- Mem_Wdata  out  32  lane-replicated store data
- Mem_Ack  in  1  one-cycle completion strobe
- Mem_Rdata  in  32  read data, valid with Mem_Ack

Behaviour:
- Clocking and reset: single clock Clk; Reset is synchronous, active-high.
- Reset values:
  - State IDLE; Mem_Req, Mem_We, Mem_Byte_En, Mem_Addr, Mem_Wdata and the internal load register all 0.
  - Combinational outputs during Reset: Stall_MEM 0, RegWrite_MEM 0, Addr_Exception 0.
- Byte order: little-endian. Byte at addr[1:0]=n occupies bits [8n+7:8n]. Half at addr[1]=h occupies bits [16h+15:16h].
- Byte enables:
  - Byte: 0001 shifted left by addr[1:0].
  - Half: 0011 shifted left by 2*addr[1].
  - Word: 1111.
- Store data lanes: byte replicated x4; half replicated x2; word as-is.
- Load data: selected lane, sign- or zero-extended per MemSigned_in. Word loads ignore MemSigned_in.
- FSM states: IDLE, REQ, DONE.
- IDLE, no access (MemRead_in=MemWrite_in=0):
  - Pure combinational pass-through; Stall_MEM=0, Read_Data_MEM=0.
  - Mem_Ack is ignored in IDLE.
- IDLE, access presented:
  - Stall_MEM=1, RegWrite_MEM=0 (bubble into MEM/WB).
  - Latch address, enables, wdata and we on the edge; next state REQ with Mem_Req=1.
- REQ:
  - Mem_Req and all bus fields held stable; Stall_MEM=1, RegWrite_MEM=0.
  - On Mem_Ack: drop Mem_Req, capture the aligned/extended Mem_Rdata (stores capture 0), next state DONE.
  - No ack: remain in REQ; no timeout.
- DONE:
  - Stall_MEM=0; outputs present the instruction with Read_Data_MEM = captured data and RegWrite_MEM = RegWrite_in.
  - Next state IDLE; the next EX/MEM instruction arrives in IDLE.
- Latency: ack in the first REQ cycle gives 2 stall cycles; each extra ack-wait cycle adds 1.
- Simultaneous MemRead_in and MemWrite_in: treated as a store.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=00.
- Reset mid-transaction: returns to IDLE; Mem_Req=0 after that edge; a late Mem_Ack is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned access in IDLE issues no bus request.
  - Addr_Exception=1 for that cycle; RegWrite_MEM=0; Stall_MEM=0.
  - Next instruction proceeds.
- Undefined: Addr_Exception tied 0.
  - Misaligned addresses are force-aligned (half clears addr[0], word clears addr[1:0]) and the access completes normally.

Test Plan:
- Non-memory op, ALU_Result_in=0x1234, RegWrite_in=1, Write_Register_in=5 -> same cycle: Stall_MEM=0, ALU_Result_MEM=0x1234, RegWrite_MEM=1, Mem_Req stays 0.
- LB signed at addr 0x103, Mem_Rdata=0x80FF_0011, ack in first REQ cycle:
  - Mem_Addr=0x100, Mem_Byte_En=1000.
  - Stall_MEM=1 for 2 cycles, then Read_Data_MEM=0xFFFF_FF80.
- LHU at 0x202, Mem_Rdata=0xBEEF_1234, ack after 3 wait cycles:
  - Mem_Byte_En=1100, Stall_MEM=1 for 5 cycles.
  - Read_Data_MEM=0x0000_BEEF.
- SB data 0x0000_00A5 at 0x001 -> Mem_We=1, Mem_Byte_En=0010, Mem_Wdata=0xA5A5_A5A5; RegWrite_MEM=0 throughout.
- Reset asserted in REQ, Mem_Ack pulsed 2 cycles later -> Mem_Req=0 after the reset edge; FSM stays IDLE; no stall; ack ignored.
- LW at 0x006:
  - With MISALIGN_TRAP_EN: Addr_Exception=1 for 1 cycle, no Mem_Req, RegWrite_MEM=0.
  - Without: Mem_Addr=0x004, Mem_Byte_En=1111, normal completion.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage load/store unit
// (master) and data memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              Mem_Req;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [BE_W-1:0]   Mem_Byte_En;
  logic [DATA_W-1:0] Mem_Wdata;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_Rdata;

  modport master (
    output Mem_Req, Mem_We, Mem_Addr, Mem_Byte_En, Mem_Wdata,
    input  Mem_Ack, Mem_Rdata
  );

  modport slave (
    input  Mem_Req, Mem_We, Mem_Addr, Mem_Byte_En, Mem_Wdata,
    output Mem_Ack, Mem_Rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MIPS32 MEM-stage load/store unit: req/ack data-memory access, load lane alignment and extension.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses raise Addr_Exception instead of being force-aligned.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemSigned_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] Write_Data_in,
  input  logic [4:0]  Write_Register_in,
  output logic        RegWrite_MEM,
  output logic        MemtoReg_MEM,
  output logic [31:0] Read_Data_MEM,
  output logic [31:0] ALU_Result_MEM,
  output logic [4:0]  Write_Register_MEM,
  output logic        Stall_MEM,
  output logic        Addr_Exception,
  mem_stage_lsu_if.master mem
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;

  logic              access_c;
  logic              trap_c;
  logic [1:0]        off_c;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c;

  // Select the addressed lane and sign/zero-extend it; word loads pass through.
  function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] rdata,
                                                  input logic [1:0] size,
                                                  input logic [1:0] off,
                                                  input logic       sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {off, 3'b000});
    h = 16'(rdata >> {off[1], 4'b0000});
    case (size)
      2'b00:   return {{(DATA_W-8){sgn & b[7]}}, b};
      2'b01:   return {{(DATA_W-16){sgn & h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  // Decode the presented access: force-aligned lane offset, enables, replicated store data.
  always_comb begin
    access_c = MemRead_in | MemWrite_in;
    off_c    = ALU_Result_in[1:0];
    be_c     = 4'b1111;
    wdata_c  = Write_Data_in;
    case (MemSize_in)
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{Write_Data_in[7:0]}};
      end
      2'b01: begin
        off_c   = {ALU_Result_in[1], 1'b0};
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{Write_Data_in[15:0]}};
      end
      default: off_c = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap_c = access_c &
                  ((MemSize_in == 2'b01) ? ALU_Result_in[0] :
                   ((MemSize_in != 2'b00) & (|ALU_Result_in[1:0])));
`else
  assign trap_c = 1'b0;
`endif

  assign MemtoReg_MEM       = MemtoReg_in;
  assign ALU_Result_MEM     = ALU_Result_in;
  assign Write_Register_MEM = Write_Register_in;

  // Next-state and stage outputs.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    load_d         = load_q;
    size_d         = size_q;
    sign_d         = sign_q;
    off_d          = off_q;
    Stall_MEM      = 1'b0;
    RegWrite_MEM   = RegWrite_in;
    Read_Data_MEM  = '0;
    Addr_Exception = 1'b0;

    case (state_q)
      IDLE: begin
        if (trap_c) begin
          Addr_Exception = 1'b1;
          RegWrite_MEM   = 1'b0;
        end else if (access_c) begin
          Stall_MEM    = 1'b1;
          RegWrite_MEM = 1'b0;
          state_d      = REQ;
          req_d        = 1'b1;
          we_d         = MemWrite_in;
          addr_d       = {ALU_Result_in[ADDR_W-1:2], 2'b00};
          be_d         = be_c;
          wdata_d      = wdata_c;
          size_d       = MemSize_in;
          sign_d       = MemSigned_in;
          off_d        = off_c;
          load_d       = '0;
        end
      end
      REQ: begin
        Stall_MEM    = 1'b1;
        RegWrite_MEM = 1'b0;
        if (mem.Mem_Ack) begin
          req_d   = 1'b0;
          load_d  = we_q ? '0 : align_load(mem.Mem_Rdata, size_q, off_q, sign_q);
          state_d = DONE;
        end
      end
      DONE: begin
        Read_Data_MEM = load_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (Reset) begin
      Stall_MEM      = 1'b0;
      RegWrite_MEM   = 1'b0;
      Addr_Exception = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
    end
  end

  assign mem.Mem_Req     = req_q;
  assign mem.Mem_We      = we_q;
  assign mem.Mem_Addr    = addr_q;
  assign mem.Mem_Byte_En = be_q;
  assign mem.Mem_Wdata   = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: random and directed instructions, a data-memory
// responder with programmable ack delay, and a byte-arithmetic reference model.
module tb_mem_stage_lsu;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        rd, wr, sgn, regw, m2r;
    logic [1:0]  size;
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  wreg;
    int unsigned delay;
  } op_t;

  typedef struct {
    logic        regw, m2r, exc;
    logic [31:0] rdata, alu;
    logic [4:0]  wreg;
    int unsigned stalls;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } bus_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        MemRead_in, MemWrite_in, MemSigned_in, RegWrite_in, MemtoReg_in;
  logic [1:0]  MemSize_in;
  logic [31:0] ALU_Result_in, Write_Data_in;
  logic [4:0]  Write_Register_in;
  logic        RegWrite_MEM, MemtoReg_MEM, Stall_MEM, Addr_Exception;
  logic [31:0] Read_Data_MEM, ALU_Result_MEM;
  logic [4:0]  Write_Register_MEM;

  mem_stage_lsu_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(clk), .Reset(Reset),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemSize_in(MemSize_in),
    .MemSigned_in(MemSigned_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .ALU_Result_in(ALU_Result_in), .Write_Data_in(Write_Data_in),
    .Write_Register_in(Write_Register_in),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Read_Data_MEM(Read_Data_MEM),
    .ALU_Result_MEM(ALU_Result_MEM), .Write_Register_MEM(Write_Register_MEM),
    .Stall_MEM(Stall_MEM), .Addr_Exception(Addr_Exception),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];

  int unsigned slave_delay = 0;
  logic [31:0] slave_rdata = '0;
  bit          slave_en    = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: byte-lane arithmetic on a little-endian 32-bit word.
  function automatic void model(input op_t o, output exp_t e, output bus_t b, output bit has_bus);
    int unsigned bytes, off, aoff;
    logic [63:0] mask, v, rep;
    bytes = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
    off   = o.alu % 32'd4;
    aoff  = off - (off % bytes);
    mask  = (64'd1 << (8 * bytes)) - 64'd1;
    rep   = (bytes == 1) ? 64'h0101_0101 : (bytes == 2) ? 64'h0001_0001 : 64'd1;
    e.alu = o.alu; e.wreg = o.wreg; e.m2r = o.m2r; e.regw = o.regw;
    e.exc = 1'b0; e.rdata = '0; e.stalls = 0;
    b.we = o.wr; b.addr = o.alu & ~32'd3; b.be = 4'(mask[3:0] << aoff);
    b.be = 4'(((64'd1 << bytes) - 64'd1) << aoff);
    b.wdata = 32'((64'(o.wdata) & mask) * rep);
    has_bus = 1'b0;
    if (!(o.rd || o.wr)) return;
    if (TRAP && (off % bytes) != 0) begin
      e.exc = 1'b1; e.regw = 1'b0;
      return;
    end
    has_bus  = 1'b1;
    e.stalls = 2 + o.delay;
    if (!o.wr) begin
      v = (64'(o.rdata) >> (8 * aoff)) & mask;
      if (bytes < 4 && o.sgn && v[8*bytes-1]) v = v | ~mask;
      e.rdata = v[31:0];
    end
  endfunction

  task automatic drive(input op_t o);
    MemRead_in = o.rd; MemWrite_in = o.wr; MemSize_in = o.size; MemSigned_in = o.sgn;
    RegWrite_in = o.regw; MemtoReg_in = o.m2r; ALU_Result_in = o.alu;
    Write_Data_in = o.wdata; Write_Register_in = o.wreg;
  endtask

  // Present one instruction and hold it until the stage accepts it.
  task automatic issue(input op_t o);
    exp_t e; bus_t b; bit hb; bit done;
    model(o, e, b, hb);
    exp_q.push_back(e);
    if (hb) bus_q.push_back(b);
    slave_delay = o.delay; slave_rdata = o.rdata;
    drive(o);
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!Stall_MEM) done = 1'b1;
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic op_t mk(input logic rd, wr, input logic [1:0] size, input logic sgn,
                             input logic [31:0] alu, wdata, rdata, input int unsigned dly);
    op_t o;
    o.rd = rd; o.wr = wr; o.size = size; o.sgn = sgn; o.alu = alu; o.wdata = wdata;
    o.rdata = rdata; o.delay = dly; o.regw = rd & ~wr; o.m2r = rd & ~wr;
    o.wreg = 5'(alu[6:2] ^ 5'd7);
    return o;
  endfunction

  // Data memory responder: ack after slave_delay wait cycles.
  initial begin : slave
    bit          active = 1'b0;
    int unsigned cnt = 0;
    mif.Mem_Ack = 1'b0; mif.Mem_Rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (slave_en) begin
        mif.Mem_Ack = 1'b0;
        if (mif.Mem_Req) begin
          if (!active) begin active = 1'b1; cnt = slave_delay; end
          if (cnt == 0) begin
            mif.Mem_Ack = 1'b1; mif.Mem_Rdata = slave_rdata; active = 1'b0;
          end else cnt--;
        end
      end else active = 1'b0;
    end
  end

  // Retirement monitor: every non-stalled cycle presents an instruction to MEM/WB.
  int unsigned stall_run = 0;
  always @(negedge clk) begin : retire_mon
    exp_t e;
    if (Reset) stall_run = 0;
    else if (Stall_MEM) begin
      stall_run++;
      chk("stall_regwrite", 64'(RegWrite_MEM), 64'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regwrite",  64'(RegWrite_MEM),       64'(e.regw));
        chk("memtoreg",  64'(MemtoReg_MEM),       64'(e.m2r));
        chk("read_data", 64'(Read_Data_MEM),      64'(e.rdata));
        chk("alu_pass",  64'(ALU_Result_MEM),     64'(e.alu));
        chk("wreg_pass", 64'(Write_Register_MEM), 64'(e.wreg));
        chk("addr_exc",  64'(Addr_Exception),     64'(e.exc));
        chk("stall_cycles", 64'(stall_run),       64'(e.stalls));
      end
      stall_run = 0;
    end
  end

  // Bus monitor: request fields must match the expected transaction every REQ cycle.
  logic req_prev = 1'b0;
  always @(negedge clk) begin : bus_mon
    if (mif.Mem_Req) begin
      if (bus_q.size() == 0) chk("bus_unexpected_req", 64'd1, 64'd0);
      else begin
        chk("bus_we",    64'(mif.Mem_We),      64'(bus_q[0].we));
        chk("bus_addr",  64'(mif.Mem_Addr),    64'(bus_q[0].addr));
        chk("bus_be",    64'(mif.Mem_Byte_En), 64'(bus_q[0].be));
        chk("bus_wdata", 64'(mif.Mem_Wdata),   64'(bus_q[0].wdata));
      end
    end else if (req_prev && bus_q.size() > 0) void'(bus_q.pop_front());
    req_prev = mif.Mem_Req;
  end

  initial begin : main
    op_t  o;
    exp_t e; bus_t b; bit hb; bit seen;
    int   kind;
    Reset = 1'b1;
    drive(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 0));
    RegWrite_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",    64'(Stall_MEM),       64'd0);
    chk("rst_regwrite", 64'(RegWrite_MEM),    64'd0);
    chk("rst_exc",      64'(Addr_Exception),  64'd0);
    chk("rst_req",      64'(mif.Mem_Req),     64'd0);
    chk("rst_we",       64'(mif.Mem_We),      64'd0);
    chk("rst_be",       64'(mif.Mem_Byte_En), 64'd0);
    chk("rst_addr",     64'(mif.Mem_Addr),    64'd0);
    chk("rst_wdata",    64'(mif.Mem_Wdata),   64'd0);
    @(posedge clk); #1;
    drive(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
    Reset = 1'b0;
    @(posedge clk); #1;

    o = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h1234, 32'h0, 32'h0, 0);
    o.regw = 1'b1; o.wreg = 5'd5;
    issue(o);
    issue(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_0011, 0));
    issue(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'hBEEF_1234, 3));
    issue(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h001, 32'h0000_00A5, 32'h0, 1));
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'hCAFE_F00D, 1));
    issue(mk(1'b1, 1'b1, 2'd1, 1'b1, 32'h0000_0F12, 32'h1234_8765, 32'hFFFF_FFFF, 0));
    issue(mk(1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_0108, 32'h0, 32'h8000_0001, 2));

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      o = mk(kind == 1 || kind == 3, kind >= 2, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 4));
      o.regw = 1'($urandom_range(0, 1)); o.m2r = 1'($urandom_range(0, 1));
      issue(o);
    end

    // Reset while a load waits in REQ, then a stray late ack.
    slave_en = 1'b0;
    o = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 0);
    model(o, e, b, hb);
    bus_q.push_back(b);
    drive(o);
    seen = 1'b0;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge clk);
      if (mif.Mem_Req) seen = 1'b1;
    end
    chk("mid_req_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    Reset = 1'b1;
    drive(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 64'(mif.Mem_Req), 64'd0);
    @(posedge clk); #1;
    mif.Mem_Ack = 1'b1; mif.Mem_Rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mif.Mem_Ack = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("late_ack_req",   64'(mif.Mem_Req), 64'd0);
      chk("late_ack_stall", 64'(Stall_MEM),   64'd0);
    end
    @(posedge clk); #1;
    slave_en = 1'b1;
    issue(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 32'h1122_3344, 1));

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
